gerenciador_partida: RTL and testbench
======================================

GERENCIADOR_PARTIDA -- requirements
Module: gerenciador_partida

Interface
REQ-001 Parameter LINHAS, default 7, number of grid rows.
REQ-002 Parameter COLUNAS, default 5, number of grid columns.
REQ-003 Parameter VIDAS, default 6, misses allowed before defeat, range 1..15.
REQ-004 clock_in  input  1  single system clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 modo  input  2  game mode: 00 desligado, 01 preparacao, 10 ataque, 11 treated as desligado.
REQ-007 confirmar  input  1  single-cycle active-high confirm pulse, already debounced.
REQ-008 coord_linha  input  LW=$clog2(LINHAS)  attack row.
REQ-009 coord_coluna  input  CW=$clog2(COLUNAS)  attack column.
REQ-010 mapa_in  input  LINHAS*COLUNAS  ship map; bit index = linha*COLUNAS+coluna.
REQ-011 acertos  output  LINHAS*COLUNAS  cells shot and hit.
REQ-012 erros  output  LINHAS*COLUNAS  cells shot and missed.
REQ-013 vida  output  $clog2(VIDAS+1)  remaining lives.
REQ-014 restantes  output  $clog2(LINHAS*COLUNAS+1)  ship cells not yet hit.
REQ-015 estado  output  3  current FSM state code.
REQ-016 LED_R, LED_G, LED_B  output  1 each  last-shot feedback.

Function
REQ-017 FSM states SHALL be OCIOSO, PREPARACAO, ATAQUE, VITORIA, DERROTA.
REQ-018 modo desligado/11 SHALL force OCIOSO next cycle from any state, clearing acertos, erros, LEDs, reloading vida=VIDAS; latched map retained.
REQ-019 OCIOSO->PREPARACAO when modo=01; ATAQUE/VITORIA/DERROTA->PREPARACAO when modo=01, clearing shots, vida=VIDAS.
REQ-020 In PREPARACAO, confirmar SHALL latch mapa_in and load restantes with its popcount next cycle; mapa_valido set if popcount>0.
REQ-021 PREPARACAO->ATAQUE when modo=10 and mapa_valido; otherwise stay and hold LED_B=1.
REQ-022 In ATAQUE, confirmar with coord_linha>=LINHAS or coord_coluna>=COLUNAS SHALL change no game state and set LED_B only.
REQ-023 Confirm on a cell already in acertos|erros SHALL cost no life and set LED_R=LED_G=1 (yellow).
REQ-024 Confirm on new ship cell: set acertos bit, restantes-1, LED_G only.
REQ-025 Confirm on new empty cell: set erros bit, vida-1, LED_R only.
REQ-026 All outputs registered; effects visible exactly one cycle after confirmar.
REQ-027 restantes reaching 0 SHALL move ATAQUE->VITORIA same edge; vida reaching 0 SHALL move ATAQUE->DERROTA same edge.
REQ-028 VITORIA/DERROTA SHALL ignore confirmar; LEDs hold G (vitoria) or R (derrota) steady.
REQ-029 vida and restantes SHALL never underflow or wrap.
REQ-030 confirmar coincident with a modo change SHALL be ignored; mode transition wins.
REQ-031 LEDs hold last feedback until next accepted confirm or state change; cleared on entering ATAQUE.

Reset
REQ-032 reset_n low SHALL asynchronously set OCIOSO, map/acertos/erros=0, mapa_valido=0, vida=VIDAS, restantes=0, LEDs=0.
REQ-033 Reset mid-attack SHALL discard all progress; release resumes from OCIOSO on next edge.

Structure
REQ-034 Shared package batalha_pkg SHALL hold state encoding, modo codes, and LED feedback codes.
REQ-035 Popcount SHALL be a sub-module contador_navios, parametrised by width, purely combinational.

Verification
REQ-036 Defaults; map bits {0,1,2} set, preparacao confirm, attack (0,0),(0,1),(0,2) -> restantes 3,2,1,0, LED_G each, estado=VITORIA after third.
REQ-037 Six misses on empty cells -> vida 6..0, LED_R each, estado=DERROTA; seventh confirm ignored.
REQ-038 Shoot (1,1) twice -> second gives yellow LEDs, vida unchanged.
REQ-039 Attack (7,0) and (0,5) -> LED_B, acertos/erros/vida/restantes unchanged.
REQ-040 Empty map confirm, modo=10 -> stays PREPARACAO, LED_B=1.
REQ-041 reset_n low mid-attack after 2 hits -> immediate OCIOSO, vida=6, acertos=0; modo=10 with confirm same cycle as modo change -> no shot recorded.

Source files
------------

// File: rtl/batalha_pkg.sv
// Shared encodings for the battleship game manager: FSM states, mode codes
// and last-shot LED feedback patterns.
package batalha_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    PREPARACAO = 3'd1,
    ATAQUE     = 3'd2,
    VITORIA    = 3'd3,
    DERROTA    = 3'd4
  } estado_t;

  typedef enum logic [1:0] {
    MODO_DESLIGADO  = 2'b00,
    MODO_PREPARACAO = 2'b01,
    MODO_ATAQUE     = 2'b10,
    MODO_RESERVADO  = 2'b11
  } modo_t;

  // Bit order is {R, G, B}
  typedef enum logic [2:0] {
    LED_APAGADO   = 3'b000,
    LED_ACERTO    = 3'b010,
    LED_ERRO      = 3'b100,
    LED_REPETIDO  = 3'b110,
    LED_INVALIDO  = 3'b001
  } led_t;

  function automatic logic modo_desliga(input modo_t m);
    return (m == MODO_DESLIGADO) || (m == MODO_RESERVADO);
  endfunction

endpackage

// File: rtl/contador_navios.sv
// Combinational population count of a ship map.
module contador_navios #(
  parameter int unsigned LARGURA = 35,
  localparam int unsigned CW     = $clog2(LARGURA + 1)
) (
  input  logic [LARGURA-1:0] i_bits,
  output logic [CW-1:0]      o_contagem
);

  always_comb begin
    o_contagem = '0;
    for (int unsigned i = 0; i < LARGURA; i++) begin
      o_contagem = o_contagem + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/gerenciador_partida.sv
// Battleship match manager: latches a ship map, scores attack shots, tracks
// lives and remaining ship cells, and reports last-shot feedback on RGB LEDs.
module gerenciador_partida
  import batalha_pkg::*;
#(
  parameter int unsigned LINHAS  = 7,
  parameter int unsigned COLUNAS = 5,
  parameter int unsigned VIDAS   = 6,
  localparam int unsigned N      = LINHAS * COLUNAS,
  localparam int unsigned LW     = $clog2(LINHAS),
  localparam int unsigned CW     = $clog2(COLUNAS),
  localparam int unsigned VW     = $clog2(VIDAS + 1),
  localparam int unsigned RW     = $clog2(N + 1)
) (
  input  logic          clock_in,
  input  logic          reset_n,
  input  logic [1:0]    modo,
  input  logic          confirmar,
  input  logic [LW-1:0] coord_linha,
  input  logic [CW-1:0] coord_coluna,
  input  logic [N-1:0]  mapa_in,
  output logic [N-1:0]  acertos,
  output logic [N-1:0]  erros,
  output logic [VW-1:0] vida,
  output logic [RW-1:0] restantes,
  output logic [2:0]    estado,
  output logic          LED_R,
  output logic          LED_G,
  output logic          LED_B
);

  localparam logic [VW-1:0] VIDA_CHEIA = VW'(VIDAS);

  estado_t       r_estado;
  led_t          r_led;
  logic [N-1:0]  r_mapa;
  logic          r_mapa_valido;
  logic [N-1:0]  r_acertos;
  logic [N-1:0]  r_erros;
  logic [VW-1:0] r_vida;
  logic [RW-1:0] r_restantes;

  modo_t         w_modo;
  logic [RW-1:0] w_pop_entrada;
  logic [RW-1:0] w_pop_mapa;
  logic          w_coord_ok;
  logic [31:0]   w_idx;
  logic [N-1:0]  w_sel;
  logic          w_navio;
  logic          w_repetido;

  contador_navios #(.LARGURA(N)) u_pop_entrada (
    .i_bits     (mapa_in),
    .o_contagem (w_pop_entrada)
  );

  // Reloads restantes from the retained map whenever shots are cleared.
  contador_navios #(.LARGURA(N)) u_pop_mapa (
    .i_bits     (r_mapa),
    .o_contagem (w_pop_mapa)
  );

  always_comb begin
    w_modo     = modo_t'(modo);
    w_coord_ok = (32'(coord_linha) < LINHAS) && (32'(coord_coluna) < COLUNAS);
    w_idx      = 32'(coord_linha) * COLUNAS + 32'(coord_coluna);
    w_sel      = w_coord_ok ? (N'(1) << w_idx) : '0;
    w_navio    = |(r_mapa & w_sel);
    w_repetido = |((r_acertos | r_erros) & w_sel);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_estado      <= OCIOSO;
      r_led         <= LED_APAGADO;
      r_mapa        <= '0;
      r_mapa_valido <= 1'b0;
      r_acertos     <= '0;
      r_erros       <= '0;
      r_vida        <= VIDA_CHEIA;
      r_restantes   <= '0;
    end else if (modo_desliga(w_modo)) begin
      r_estado    <= OCIOSO;
      r_led       <= LED_APAGADO;
      r_acertos   <= '0;
      r_erros     <= '0;
      r_vida      <= VIDA_CHEIA;
      r_restantes <= w_pop_mapa;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_modo == MODO_PREPARACAO) r_estado <= PREPARACAO;
        end

        PREPARACAO: begin
          if (w_modo == MODO_PREPARACAO) begin
            if (confirmar) begin
              r_mapa        <= mapa_in;
              r_restantes   <= w_pop_entrada;
              r_mapa_valido <= (w_pop_entrada != '0);
            end
          end else if (r_mapa_valido) begin
            r_estado <= ATAQUE;
            r_led    <= LED_APAGADO;
          end else begin
            r_led <= LED_INVALIDO;
          end
        end

        ATAQUE, VITORIA, DERROTA: begin
          if (w_modo == MODO_PREPARACAO) begin
            r_estado    <= PREPARACAO;
            r_led       <= LED_APAGADO;
            r_acertos   <= '0;
            r_erros     <= '0;
            r_vida      <= VIDA_CHEIA;
            r_restantes <= w_pop_mapa;
          end else if ((r_estado == ATAQUE) && confirmar) begin
            if (!w_coord_ok) begin
              r_led <= LED_INVALIDO;
            end else if (w_repetido) begin
              r_led <= LED_REPETIDO;
            end else if (w_navio) begin
              r_acertos <= r_acertos | w_sel;
              r_led     <= LED_ACERTO;
              if (r_restantes != '0) r_restantes <= r_restantes - RW'(1);
              if (r_restantes <= RW'(1)) r_estado <= VITORIA;
            end else begin
              r_erros <= r_erros | w_sel;
              r_led   <= LED_ERRO;
              if (r_vida != '0) r_vida <= r_vida - VW'(1);
              if (r_vida <= VW'(1)) r_estado <= DERROTA;
            end
          end
        end

        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign estado    = r_estado;
  assign acertos   = r_acertos;
  assign erros     = r_erros;
  assign vida      = r_vida;
  assign restantes = r_restantes;
  assign LED_R     = r_led[2];
  assign LED_G     = r_led[1];
  assign LED_B     = r_led[0];

endmodule

// File: tb/tb_gerenciador_partida.sv
// Self-checking bench for gerenciador_partida: directed vector table, reset
// and mode-change sequences, then random play against a rule-level model.
module tb_gerenciador_partida;

  localparam int L = 7;
  localparam int C = 5;
  localparam int V = 6;
  localparam int N = L * C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    modo;
  logic          confirmar;
  logic [2:0]    coord_linha;
  logic [2:0]    coord_coluna;
  logic [N-1:0]  mapa_in;
  logic [N-1:0]  acertos;
  logic [N-1:0]  erros;
  logic [2:0]    vida;
  logic [5:0]    restantes;
  logic [2:0]    estado;
  logic          LED_R, LED_G, LED_B;

  int n_checks = 0;
  int n_errors = 0;

  // Rule-level model: phase, latched map, sets of shot cells, LED pattern {R,G,B}
  int           m_fase;
  logic [N-1:0] m_map;
  logic         m_valido;
  logic [N-1:0] m_hits;
  logic [N-1:0] m_miss;
  logic [2:0]   m_led;

  gerenciador_partida #(.LINHAS(L), .COLUNAS(C), .VIDAS(V)) dut (
    .clock_in     (clk),
    .reset_n      (rst_n),
    .modo         (modo),
    .confirmar    (confirmar),
    .coord_linha  (coord_linha),
    .coord_coluna (coord_coluna),
    .mapa_in      (mapa_in),
    .acertos      (acertos),
    .erros        (erros),
    .vida         (vida),
    .restantes    (restantes),
    .estado       (estado),
    .LED_R        (LED_R),
    .LED_G        (LED_G),
    .LED_B        (LED_B)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           md;
    int           cf;
    int           l;
    int           c;
    logic [N-1:0] mp;
    int           e_estado;
    int           e_rest;
    int           e_vida;
    int           e_led;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nome, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fase = 0; m_map = '0; m_valido = 1'b0; m_hits = '0; m_miss = '0; m_led = 3'b000;
  endtask

  task automatic model_step(input int md, input int cf, input int l, input int c, input logic [N-1:0] mp);
    int k;
    if (md == 0 || md == 3) begin
      m_fase = 0; m_hits = '0; m_miss = '0; m_led = 3'b000;
    end else if (m_fase == 0) begin
      if (md == 1) m_fase = 1;
    end else if (m_fase == 1) begin
      if (md == 1) begin
        if (cf != 0) begin m_map = mp; m_valido = (mp != '0); end
      end else if (m_valido) begin
        m_fase = 2; m_led = 3'b000;
      end else begin
        m_led = 3'b001;
      end
    end else begin
      if (md == 1) begin
        m_fase = 1; m_hits = '0; m_miss = '0; m_led = 3'b000;
      end else if (m_fase == 2 && cf != 0) begin
        if (l >= L || c >= C) begin
          m_led = 3'b001;
        end else begin
          k = l * C + c;
          if (m_hits[k] || m_miss[k]) m_led = 3'b110;
          else if (m_map[k]) begin
            m_hits[k] = 1'b1; m_led = 3'b010;
            if ($countones(m_hits) == $countones(m_map)) m_fase = 3;
          end else begin
            m_miss[k] = 1'b1; m_led = 3'b100;
            if ($countones(m_miss) == V) m_fase = 4;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("estado", estado, m_fase);
    chk("acertos", acertos, m_hits);
    chk("erros", erros, m_miss);
    chk("vida", vida, V - $countones(m_miss));
    chk("restantes", restantes, $countones(m_map) - $countones(m_hits));
    chk("leds", {LED_R, LED_G, LED_B}, m_led);
  endtask

  task automatic cycle(input int md, input int cf, input int l, input int c, input logic [N-1:0] mp);
    modo = 2'(md); confirmar = (cf != 0); coord_linha = 3'(l); coord_coluna = 3'(c); mapa_in = mp;
    @(posedge clk);
    model_step(md, cf, l, c, mp);
    #1;
    check_model();
  endtask

  task automatic add(input int md, input int cf, input int l, input int c, input logic [N-1:0] mp,
                     input int es, input int rs, input int vd, input int ld);
    vec_t v;
    v.md = md; v.cf = cf; v.l = l; v.c = c; v.mp = mp;
    v.e_estado = es; v.e_rest = rs; v.e_vida = vd; v.e_led = ld;
    vecs.push_back(v);
  endtask

  initial begin
    logic [N-1:0] m3;
    logic [N-1:0] z;
    m3 = N'(7);
    z  = '0;

    rst_n = 1'b0; modo = 2'b00; confirmar = 1'b0;
    coord_linha = '0; coord_coluna = '0; mapa_in = '0;
    model_reset();
    #12;
    check_model();
    chk("reset_estado", estado, 0);
    chk("reset_vida", vida, 6);
    @(negedge clk);
    rst_n = 1'b1;

    // Win, miss/repeat/out-of-range, defeat, empty-map, power-off
    add(1, 0, 0, 0, z,  1, 0, 6, 3'b000);
    add(1, 1, 0, 0, m3, 1, 3, 6, 3'b000);
    add(2, 0, 0, 0, z,  2, 3, 6, 3'b000);
    add(2, 1, 0, 0, z,  2, 2, 6, 3'b010);
    add(2, 1, 0, 1, z,  2, 1, 6, 3'b010);
    add(2, 1, 0, 2, z,  3, 0, 6, 3'b010);
    add(2, 1, 1, 1, z,  3, 0, 6, 3'b010);
    add(1, 0, 0, 0, z,  1, 3, 6, 3'b000);
    add(2, 0, 0, 0, z,  2, 3, 6, 3'b000);
    add(2, 1, 1, 1, z,  2, 3, 5, 3'b100);
    add(2, 1, 1, 1, z,  2, 3, 5, 3'b110);
    add(2, 1, 7, 0, z,  2, 3, 5, 3'b001);
    add(2, 1, 0, 5, z,  2, 3, 5, 3'b001);
    add(2, 1, 0, 0, z,  2, 2, 5, 3'b010);
    add(2, 1, 0, 0, z,  2, 2, 5, 3'b110);
    add(1, 0, 0, 0, z,  1, 3, 6, 3'b000);
    add(2, 0, 0, 0, z,  2, 3, 6, 3'b000);
    add(2, 1, 1, 0, z,  2, 3, 5, 3'b100);
    add(2, 1, 1, 1, z,  2, 3, 4, 3'b100);
    add(2, 1, 1, 2, z,  2, 3, 3, 3'b100);
    add(2, 1, 1, 3, z,  2, 3, 2, 3'b100);
    add(2, 1, 1, 4, z,  2, 3, 1, 3'b100);
    add(2, 1, 2, 0, z,  4, 3, 0, 3'b100);
    add(2, 1, 2, 1, z,  4, 3, 0, 3'b100);
    add(1, 0, 0, 0, z,  1, 3, 6, 3'b000);
    add(1, 1, 0, 0, z,  1, 0, 6, 3'b000);
    add(2, 1, 0, 0, z,  1, 0, 6, 3'b001);
    add(2, 0, 0, 0, z,  1, 0, 6, 3'b001);
    add(0, 0, 0, 0, z,  0, 0, 6, 3'b000);

    foreach (vecs[i]) begin
      cycle(vecs[i].md, vecs[i].cf, vecs[i].l, vecs[i].c, vecs[i].mp);
      chk($sformatf("vec%0d_estado", i), estado, vecs[i].e_estado);
      chk($sformatf("vec%0d_restantes", i), restantes, vecs[i].e_rest);
      chk($sformatf("vec%0d_vida", i), vida, vecs[i].e_vida);
      chk($sformatf("vec%0d_leds", i), {LED_R, LED_G, LED_B}, vecs[i].e_led);
    end

    // Asynchronous reset in the middle of an attack
    cycle(1, 0, 0, 0, z);
    cycle(1, 1, 0, 0, m3);
    cycle(2, 0, 0, 0, z);
    cycle(2, 1, 0, 0, z);
    cycle(2, 1, 0, 1, z);
    chk("pre_reset_restantes", restantes, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_estado", estado, 0);
    chk("async_vida", vida, 6);
    chk("async_acertos", acertos, 0);
    chk("async_restantes", restantes, 0);
    chk("async_leds", {LED_R, LED_G, LED_B}, 0);
    #3;
    rst_n = 1'b1;

    // Confirm arriving with the switch into attack mode must not fire a shot
    cycle(1, 0, 0, 0, z);
    cycle(1, 1, 0, 0, m3);
    cycle(2, 1, 0, 0, z);
    chk("modo_change_estado", estado, 2);
    chk("modo_change_acertos", acertos, 0);
    chk("modo_change_restantes", restantes, 3);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      int r, md;
      logic [N-1:0] mp;
      r = int'($urandom_range(0, 99));
      md = (r < 72) ? 2 : (r < 92) ? 1 : (r < 96) ? 0 : 3;
      mp = N'({$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()});
      if ($urandom_range(0, 9) == 0) mp = '0;
      cycle(md, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), mp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
